// File: rtl/replay_buffer_if.sv
// replay_buffer_if: byte-strobe bus between the sequencer controls, the
// replay buffer and the downstream byte consumer.
//   master : drives in_ready/in_data, record_en, replay_start, replay_en;
//            observes out_ready/out_data, busy, full, count.
//   slave  : the replay buffer side (directions mirrored).
// DEPTH sizes the count field ($clog2(DEPTH)+1 bits).
interface replay_buffer_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_ready;
  logic [7:0]    in_data;
  logic          record_en;
  logic          replay_start;
  logic          replay_en;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          busy;
  logic          full;
  logic [CW-1:0] count;

  modport master (
    output in_ready, in_data, record_en, replay_start, replay_en,
    input  out_ready, out_data, busy, full, count
  );

  modport slave (
    input  in_ready, in_data, record_en, replay_start, replay_en,
    output out_ready, out_data, busy, full, count
  );
endinterface

// File: rtl/replay_buffer.sv
// replay_buffer: captures in_ready/in_data byte strobes while record_en is
// high and plays them back as single-cycle out_ready/out_data strobes, one
// byte every GAP+1 cycles, after a replay_start pulse.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - replay_buffer_if.slave (record inputs, replay controls,
//            out_ready/out_data strobe, busy, full, count)
// Parameters: DEPTH (power of two, >= 2), GAP (>= 1).
// Optional feature: define REPLAY_LOOP_EN to repeat playback indefinitely
// (wrap to the first byte) until replay_en drops; default is single pass.
module replay_buffer #(
  parameter int DEPTH = 16,
  parameter int GAP   = 5
) (
  input logic            clk,
  input logic            resetn,
  replay_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [7:0]    mem_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic [CW-1:0] rd_r;
  logic [GW-1:0] gap_r;
  logic          rec_prev_r;
  logic          out_ready_r;
  logic [7:0]    out_data_r;
  logic          play_s;
  logic          busy_s;
  logic          rd_end_s;
  logic          wrap_s;
  logic          rec_rise_s;
  logic          wr_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;

  assign rd_end_s = (rd_r == count_r);

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.replay_start && bus.replay_en && (count_r != {CW{1'b0}})) begin
          state_nx_s = PLAY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PLAY: begin
        if (!bus.replay_en) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      WAIT: begin
        if (!bus.replay_en) begin
          state_nx_s = IDLE;
        end else if (gap_r != {GW{1'b0}}) begin
          state_nx_s = WAIT;
        end else if (!rd_end_s) begin
          state_nx_s = PLAY;
        end else begin
`ifdef REPLAY_LOOP_EN
          state_nx_s = PLAY;
`else
          state_nx_s = IDLE;
`endif
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM outputs and record-path control
  always_comb begin
    play_s     = (state_r == PLAY);
    busy_s     = (state_r != IDLE);
    // Only reachable in the loop build: last byte done, start over at 0.
    wrap_s     = (state_r == WAIT) && (state_nx_s == PLAY) && rd_end_s;
    rec_rise_s = bus.record_en && !rec_prev_r;
    wr_s       = bus.record_en && bus.in_ready;
    count_nx_s = count_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = count_r[AW-1:0];
    if (busy_s) begin
      count_nx_s = count_r;
    end else if (rec_rise_s) begin
      // A strobe coinciding with the clearing edge lands in slot 0.
      count_nx_s = wr_s ? CW'(1) : {CW{1'b0}};
      wr_en_s    = wr_s;
      wr_idx_s   = {AW{1'b0}};
    end else if (wr_s && (count_r != DEPTH_C)) begin
      count_nx_s = count_r + CW'(1);
      wr_en_s    = 1'b1;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Byte storage; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= bus.in_data;
    end
  end

  // Counters, edge detector and registered output strobe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r     <= {CW{1'b0}};
      rd_r        <= {CW{1'b0}};
      gap_r       <= {GW{1'b0}};
      rec_prev_r  <= 1'b0;
      out_ready_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      count_r    <= count_nx_s;
      rec_prev_r <= bus.record_en;
      if ((state_r == IDLE) || wrap_s) begin
        rd_r <= {CW{1'b0}};
      end else if (play_s) begin
        rd_r <= rd_r + CW'(1);
      end else begin
        rd_r <= rd_r;
      end
      // WAIT lasts GAP cycles: load GAP-1, leave when it reads 0.
      if (play_s) begin
        gap_r <= GAP_LOAD;
      end else if ((state_r == WAIT) && (gap_r != {GW{1'b0}})) begin
        gap_r <= gap_r - GW'(1);
      end else begin
        gap_r <= gap_r;
      end
      out_ready_r <= play_s;
      if (play_s) begin
        out_data_r <= mem_r[rd_r[AW-1:0]];
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign bus.out_ready = out_ready_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_s;
  assign bus.full      = (count_r == DEPTH_C);
  assign bus.count     = count_r;
endmodule

// File: tb/tb_replay_buffer.sv
// tb_replay_buffer: directed self-checking bench for replay_buffer
// (DEPTH=16, GAP=5, default single-pass build).
module tb_replay_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt;
  logic [7:0] sdata[$];
  int   stime[$];

  replay_buffer_if #(.DEPTH(16)) bus ();

  replay_buffer #(.DEPTH(16), .GAP(5)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse replay_start, then watch ncyc edges logging busy and strobes.
  task automatic run_replay(input int ncyc);
    sdata.delete();
    stime.delete();
    busy_cnt = 0;
    bus.replay_start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (i == 0) bus.replay_start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.out_ready) begin
        sdata.push_back(bus.out_data);
        stime.push_back(i);
      end
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!bus.out_ready && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.out_ready), 32'd1);
  endtask

  initial begin
    bus.in_ready = 1'b0;
    bus.in_data = 8'h00;
    bus.record_en = 1'b0;
    bus.replay_start = 1'b0;
    bus.replay_en = 1'b0;
    #12;
    chk("rst_out_ready", 32'(bus.out_ready), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    resetn = 1'b1;
    tick();

    // Record two bytes
    bus.record_en = 1'b1;
    tick();
    bus.in_ready = 1'b1;
    bus.in_data = 8'h31;
    tick();
    bus.in_data = 8'h32;
    tick();
    bus.in_ready = 1'b0;
    bus.record_en = 1'b0;
    tick();
    chk("rec2_count", 32'(bus.count), 32'd2);
    chk("rec2_full", 32'(bus.full), 32'd0);

    // Replay them: strobe one cycle after PLAY entry, 6 apart, 12 busy cycles
    bus.replay_en = 1'b1;
    run_replay(20);
    chk("rep_nstrobe", 32'(sdata.size()), 32'd2);
    chk("rep_byte0", 32'(sdata[0]), 32'h31);
    chk("rep_byte1", 32'(sdata[1]), 32'h32);
    chk("rep_latency", 32'(stime[0]), 32'd1);
    chk("rep_period", 32'(stime[1] - stime[0]), 32'd6);
    chk("rep_busy", 32'(busy_cnt), 32'd12);
    chk("rep_hold", 32'(bus.out_data), 32'h32);

    // Back-to-back: start in the first IDLE cycle after busy falls
    run_replay(13);
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    run_replay(20);
    chk("b2b_nstrobe", 32'(sdata.size()), 32'd2);
    chk("b2b_latency", 32'(stime[0]), 32'd1);
    chk("b2b_busy", 32'(busy_cnt), 32'd12);

    // Empty buffer: rising record_en edge alone clears count
    bus.record_en = 1'b1;
    tick();
    bus.record_en = 1'b0;
    tick();
    chk("clr_count", 32'(bus.count), 32'd0);
    run_replay(10);
    chk("empty_nstrobe", 32'(sdata.size()), 32'd0);
    chk("empty_busy", 32'(busy_cnt), 32'd0);

    // Overflow: 20 strobes, first coincides with the clearing edge
    bus.record_en = 1'b1;
    bus.in_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      tick();
    end
    bus.in_ready = 1'b0;
    bus.record_en = 1'b0;
    tick();
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);

    // Start with replay_en low is ignored
    bus.replay_en = 1'b0;
    run_replay(10);
    chk("dis_nstrobe", 32'(sdata.size()), 32'd0);
    chk("dis_busy", 32'(busy_cnt), 32'd0);

    // Full replay: exactly the first 16 bytes
    bus.replay_en = 1'b1;
    run_replay(100);
    chk("ovf_nstrobe", 32'(sdata.size()), 32'd16);
    chk("ovf_busy", 32'(busy_cnt), 32'd96);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_byte%0d", i), 32'(sdata[i]), 32'h40 + 32'(i));
    end

    // Abort a 4-byte replay after the first strobe
    bus.record_en = 1'b1;
    bus.in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h50 + 8'(i);
      tick();
    end
    bus.in_ready = 1'b0;
    bus.record_en = 1'b0;
    tick();
    chk("abt_count", 32'(bus.count), 32'd4);
    bus.replay_start = 1'b1;
    tick();
    bus.replay_start = 1'b0;
    wait_strobe("abt_first_strobe");
    chk("abt_byte0", 32'(bus.out_data), 32'h50);
    bus.replay_en = 1'b0;
    tick();
    chk("abt_busy", 32'(bus.busy), 32'd0);
    busy_cnt = 0;
    sdata.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_ready) sdata.push_back(bus.out_data);
      if (bus.busy) busy_cnt++;
    end
    chk("abt_nstrobe", 32'(sdata.size()), 32'd0);
    chk("abt_busy_after", 32'(busy_cnt), 32'd0);

    // Reset during WAIT
    bus.replay_en = 1'b1;
    bus.replay_start = 1'b1;
    tick();
    bus.replay_start = 1'b0;
    wait_strobe("mrst_first_strobe");
    tick();
    tick();
    chk("mrst_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_out_ready", 32'(bus.out_ready), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'h00);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_full", 32'(bus.full), 32'd0);
    #10;
    resetn = 1'b1;
    tick();
    run_replay(20);
    chk("mrst_nstrobe", 32'(sdata.size()), 32'd0);
    chk("mrst_busy_after", 32'(busy_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
